memwb_skid_stage: RTL and testbench
===================================

// Module: memwb_skid_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//  Sits between the data-memory stage and register-file write-back.
//  Adds stall (back-pressure), flush, write-back data selection, $zero write suppression
//  and a retired-instruction counter.
// PARAMETERS
//  DATA_W    32  width of ReadData / ALUResult / write-back data
//  REG_AW    5   register-address width
//  CNT_W     32  retired-instruction counter width
//  ZERO_SUPP 1   1: force RegWriteOut=0 when WriteRegisterOut==0; 0: no suppression
// PORTS
//  Clk              in   1       clock, rising edge
//  Rst_n            in   1       asynchronous reset, active-low
//  Flush            in   1       synchronous flush, drops all held entries
//  InValid          in   1       upstream entry valid
//  InReady          out  1       stage can accept an entry (registered)
//  WB               in   2       [1]=RegWrite, [0]=MemToReg
//  ReadData         in   DATA_W  memory load data
//  ALUResult        in   DATA_W  ALU result
//  WriteRegister    in   REG_AW  destination register
//  OutValid         out  1       output entry valid
//  OutReady         in   1       write-back consumes the entry
//  MemToRegOut      out  1       held WB[0]
//  RegWriteOut      out  1       WB[1] & OutValid & ~(ZERO_SUPP & dest==0)
//  ReadDataOut      out  DATA_W  held ReadData
//  ALUResultOut     out  DATA_W  held ALUResult
//  WriteRegisterOut out  REG_AW  held WriteRegister
//  WriteDataOut     out  DATA_W  MemToRegOut ? ReadDataOut : ALUResultOut (combinational)
//  debugWrite_data  out  DATA_W  equal to WriteDataOut
//  RetireCount      out  CNT_W   number of retired entries
// BEHAVIOUR
//  Reset (Rst_n=0, async): main/skid valid=0, all data regs=0, RetireCount=0, InReady=1.
//  Accept = InValid & InReady.  Retire = OutValid & OutReady.
//  Storage: main entry (drives outputs, OutValid=main_v) + skid entry (skid_v).
//  InReady = ~skid_v, registered; deasserts the cycle after the skid fills.
//  Per-edge update, main free = ~main_v | OutReady:
//   - main free & skid_v: main<=skid, skid_v<=Accept?1:0, skid<=input if Accept.
//   - main free & ~skid_v: main<=input, main_v<=Accept.
//   - main not free & Accept: skid<=input, skid_v<=1.
//   - otherwise hold.
//  Latency: 1 cycle input->output when not stalled; full throughput (1/cycle) with OutReady=1.
//  Order preserved; no entry dropped or duplicated except by Flush.
//  Flush (sync): main_v<=0, skid_v<=0, InReady<=1; entry accepted in the flush cycle is dropped;
//   data regs may hold stale values; a retire in the flush cycle is not counted.
//  Flush has priority over all updates; reset has priority over Flush.
//  RetireCount += 1 on Retire (not Flush); wraps 2^CNT_W-1 -> 0.
//  RegWriteOut/WriteDataOut are valid only while OutValid=1; RegWriteOut=0 when OutValid=0.
//  Reset mid-operation: all entries lost, outputs return to reset values immediately.
// TESTING
//  1 Reset: Rst_n=0 async mid-cycle -> OutValid=0, InReady=1, RetireCount=0, all data outputs 0.
//  2 Stream: 4 entries back-to-back, OutReady=1, ALUResult=1..4, WB=2'b10, dest=5 ->
//    one per cycle after 1-cycle latency, WriteDataOut=1..4, RegWriteOut=1, RetireCount=4.
//  3 Stall: OutReady=0 while feeding A,B,C -> A in main, B in skid, InReady=0 after B;
//    C held upstream; OutReady=1 -> A,B,C emerge in order, none lost.
//  4 Load select: WB=2'b11, ReadData=0xDEADBEEF, ALUResult=0x10 -> WriteDataOut=0xDEADBEEF;
//    WB=2'b10 -> 0x10.
//  5 $zero: WB=2'b10, WriteRegister=0, ZERO_SUPP=1 -> RegWriteOut=0, entry still retires/counted;
//    ZERO_SUPP=0 -> RegWriteOut=1.
//  6 Flush: main and skid full, Flush=1 with InValid=1, OutReady=1 -> next cycle OutValid=0,
//    InReady=1, RetireCount unchanged; CNT_W=4 at 15 plus one retire -> 0.

Source files
------------

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: valid/ready handshake with a main + skid entry, write-back mux, $zero suppression, retire counter.
// Latency: 1 cycle input->output when not stalled; sustains one entry per cycle while OutReady=1.
// Backpressure: InReady (registered) drops once the skid entry fills and returns when the skid drains or on Flush.
//
// Ports:
//   Clk, Rst_n (async, active-low), Flush (sync, drops all held entries)
//   InValid/InReady     upstream handshake; WB[1]=RegWrite, WB[0]=MemToReg, ReadData, ALUResult, WriteRegister
//   OutValid/OutReady   write-back handshake; MemToRegOut, RegWriteOut, ReadDataOut, ALUResultOut, WriteRegisterOut
//   WriteDataOut        MemToRegOut ? ReadDataOut : ALUResultOut; debugWrite_data mirrors it
//   RetireCount         number of entries consumed downstream (wraps)
module memwb_skid_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 32,
  parameter int ZERO_SUPP = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        WB,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [REG_AW-1:0] WriteRegister,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              MemToRegOut,
  output logic              RegWriteOut,
  output logic [DATA_W-1:0] ReadDataOut,
  output logic [DATA_W-1:0] ALUResultOut,
  output logic [REG_AW-1:0] WriteRegisterOut,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic [DATA_W-1:0] debugWrite_data,
  output logic [CNT_W-1:0]  RetireCount
);

  // Main entry drives the outputs; skid entry catches the one extra beat
  // that arrives while the registered InReady is still high during a stall.
  logic              main_v_q, main_v_d;
  logic [1:0]        main_wb_q, main_wb_d;
  logic [DATA_W-1:0] main_rd_q, main_rd_d;
  logic [DATA_W-1:0] main_alu_q, main_alu_d;
  logic [REG_AW-1:0] main_wr_q, main_wr_d;

  logic              skid_v_q, skid_v_d;
  logic [1:0]        skid_wb_q, skid_wb_d;
  logic [DATA_W-1:0] skid_rd_q, skid_rd_d;
  logic [DATA_W-1:0] skid_alu_q, skid_alu_d;
  logic [REG_AW-1:0] skid_wr_q, skid_wr_d;

  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic retire;
  logic main_free;
  logic dest_is_zero;

  assign accept    = InValid & in_ready_q;
  assign retire    = main_v_q & OutReady;
  assign main_free = ~main_v_q | OutReady;

  always_comb begin
    main_v_d   = main_v_q;
    main_wb_d  = main_wb_q;
    main_rd_d  = main_rd_q;
    main_alu_d = main_alu_q;
    main_wr_d  = main_wr_q;
    skid_v_d   = skid_v_q;
    skid_wb_d  = skid_wb_q;
    skid_rd_d  = skid_rd_q;
    skid_alu_d = skid_alu_q;
    skid_wr_d  = skid_wr_q;

    if (Flush) begin
      // Data registers keep stale contents; only the valid bits matter.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (main_free && skid_v_q) begin
      // Skid holds the older entry, so it moves to main first; a new
      // beat (if any) takes the skid slot to preserve order.
      main_v_d   = 1'b1;
      main_wb_d  = skid_wb_q;
      main_rd_d  = skid_rd_q;
      main_alu_d = skid_alu_q;
      main_wr_d  = skid_wr_q;
      skid_v_d   = accept;
      if (accept) begin
        skid_wb_d  = WB;
        skid_rd_d  = ReadData;
        skid_alu_d = ALUResult;
        skid_wr_d  = WriteRegister;
      end
    end else if (main_free) begin
      main_v_d = accept;
      if (accept) begin
        main_wb_d  = WB;
        main_rd_d  = ReadData;
        main_alu_d = ALUResult;
        main_wr_d  = WriteRegister;
      end
    end else if (accept) begin
      skid_v_d   = 1'b1;
      skid_wb_d  = WB;
      skid_rd_d  = ReadData;
      skid_alu_d = ALUResult;
      skid_wr_d  = WriteRegister;
    end

    in_ready_d = ~skid_v_d;

    cnt_d = cnt_q;
    if (retire && !Flush) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_v_q   <= 1'b0;
      main_wb_q  <= '0;
      main_rd_q  <= '0;
      main_alu_q <= '0;
      main_wr_q  <= '0;
      skid_v_q   <= 1'b0;
      skid_wb_q  <= '0;
      skid_rd_q  <= '0;
      skid_alu_q <= '0;
      skid_wr_q  <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_v_q   <= main_v_d;
      main_wb_q  <= main_wb_d;
      main_rd_q  <= main_rd_d;
      main_alu_q <= main_alu_d;
      main_wr_q  <= main_wr_d;
      skid_v_q   <= skid_v_d;
      skid_wb_q  <= skid_wb_d;
      skid_rd_q  <= skid_rd_d;
      skid_alu_q <= skid_alu_d;
      skid_wr_q  <= skid_wr_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  // Writes to $zero are architecturally discarded; drop the strobe here
  // so the register file never needs its own check.
  assign dest_is_zero = (ZERO_SUPP != 0) && (main_wr_q == '0);

  assign InReady          = in_ready_q;
  assign OutValid         = main_v_q;
  assign MemToRegOut      = main_wb_q[0];
  assign RegWriteOut      = main_wb_q[1] & main_v_q & ~dest_is_zero;
  assign ReadDataOut      = main_rd_q;
  assign ALUResultOut     = main_alu_q;
  assign WriteRegisterOut = main_wr_q;
  assign WriteDataOut     = main_wb_q[0] ? main_rd_q : main_alu_q;
  assign debugWrite_data  = WriteDataOut;
  assign RetireCount      = cnt_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
module tb_memwb_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  wb = 2'b00;
  logic [31:0] rd = '0;
  logic [31:0] alu = '0;
  logic [4:0]  wr = '0;

  // dut0: defaults (ZERO_SUPP=1, CNT_W=32); dut1: ZERO_SUPP=0, CNT_W=4
  logic        in_ready0, ov0, m2r0, rw0;
  logic [31:0] rdo0, aluo0, wd0, dbg0, cnt0;
  logic [4:0]  wro0;
  logic        in_ready1, ov1, m2r1, rw1;
  logic [31:0] rdo1, aluo1, wd1, dbg1;
  logic [4:0]  wro1;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  memwb_skid_stage dut0 (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready0),
    .WB(wb), .ReadData(rd), .ALUResult(alu), .WriteRegister(wr),
    .OutValid(ov0), .OutReady(out_ready), .MemToRegOut(m2r0), .RegWriteOut(rw0),
    .ReadDataOut(rdo0), .ALUResultOut(aluo0), .WriteRegisterOut(wro0),
    .WriteDataOut(wd0), .debugWrite_data(dbg0), .RetireCount(cnt0)
  );

  memwb_skid_stage #(.CNT_W(4), .ZERO_SUPP(0)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready1),
    .WB(wb), .ReadData(rd), .ALUResult(alu), .WriteRegister(wr),
    .OutValid(ov1), .OutReady(out_ready), .MemToRegOut(m2r1), .RegWriteOut(rw1),
    .ReadDataOut(rdo1), .ALUResultOut(aluo1), .WriteRegisterOut(wro1),
    .WriteDataOut(wd1), .debugWrite_data(dbg1), .RetireCount(cnt1)
  );

  typedef struct {
    logic [31:0] wdata;
    logic        rw0;
    logic        rw1;
    logic [4:0]  dest;
    logic        m2r;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: a retire happens at the next posedge when OutValid & OutReady
  // are seen here; Flush cycles drop the entry instead.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (!ov0) begin
        chk("regwrite_idle", {31'b0, rw0}, 32'd0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got wdata %0h expected none", wd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wdata",         wd0,              mon_e.wdata);
          chk("debug_wdata",   dbg0,             mon_e.wdata);
          chk("wdata_dut1",    wd1,              mon_e.wdata);
          chk("regwrite",      {31'b0, rw0},     {31'b0, mon_e.rw0});
          chk("regwrite_nozs", {31'b0, rw1},     {31'b0, mon_e.rw1});
          chk("dest",          {27'b0, wro0},    {27'b0, mon_e.dest});
          chk("memtoreg",      {31'b0, m2r0},    {31'b0, mon_e.m2r});
        end
      end
    end
  end

  // Present one entry; expectation is queued on the cycle it is accepted.
  task automatic send(input logic [1:0] w, input logic [31:0] r, input logic [31:0] a,
                      input logic [4:0] d, input logic [31:0] e_wd, input logic e_rw0,
                      input logic e_rw1);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1; wb = w; rd = r; alu = a; wr = d;
    while (1) begin
      @(negedge clk);
      if (in_ready0) break;
      n++;
      if (n > 50) begin
        checks++;
        fails++;
        $display("FAIL send_timeout: got InReady 0 expected 1 within 50 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    e.wdata = e_wd; e.rw0 = e_rw0; e.rw1 = e_rw1; e.dest = d; e.m2r = w[0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ov0) break;
      n++;
      if (n > 50) begin
        checks++;
        fails++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        break;
      end
    end
  endtask

  task automatic to_cycle_start();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    // 1: async reset, observed before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outvalid", {31'b0, ov0},       32'd0);
    chk("rst_inready",  {31'b0, in_ready0}, 32'd1);
    chk("rst_count",    cnt0,               32'd0);
    chk("rst_wdata",    wd0,                32'd0);
    chk("rst_alu",      aluo0,              32'd0);
    chk("rst_rdata",    rdo0,               32'd0);
    chk("rst_dest",     {27'b0, wro0},      32'd0);
    chk("rst_regwrite", {31'b0, rw0},       32'd0);
    #11 rst_n = 1'b1;
    to_cycle_start();

    // 2: back-to-back stream, OutReady=1
    out_ready = 1'b1;
    t0 = int'($time);
    send(2'b10, 32'hAAAA0001, 32'd1, 5'd5, 32'd1, 1'b1, 1'b1);
    chk("latency_1cycle", {31'b0, ov0}, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      send(2'b10, 32'hAAAA0000 + i, i, 5'd5, i, 1'b1, 1'b1);
    end
    chk("throughput_40", int'($time) - t0, 32'd40);
    wait_drain();
    chk("count_after_stream", cnt0, 32'd4);
    to_cycle_start();

    // 3: stall with skid fill, third entry held upstream
    out_ready = 1'b0;
    send(2'b10, 32'h0, 32'hA, 5'd6, 32'hA, 1'b1, 1'b1);
    send(2'b10, 32'h0, 32'hB, 5'd6, 32'hB, 1'b1, 1'b1);
    chk("stall_inready", {31'b0, in_ready0}, 32'd0);
    chk("stall_head",    wd0,                32'hA);
    fork
      send(2'b10, 32'h0, 32'hC, 5'd6, 32'hC, 1'b1, 1'b1);
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold_inready", {31'b0, in_ready0}, 32'd0);
    chk("stall_hold_head",    wd0,                32'hA);
    chk("stall_c_upstream",   exp_q.size(),       32'd2);
    out_ready = 1'b1;
    wait_drain();
    chk("count_after_stall", cnt0, 32'd7);
    to_cycle_start();

    // 4: load vs ALU select
    send(2'b11, 32'hDEADBEEF, 32'h10, 5'd7, 32'hDEADBEEF, 1'b1, 1'b1);
    send(2'b10, 32'hDEADBEEF, 32'h10, 5'd7, 32'h10,       1'b1, 1'b1);
    wait_drain();
    chk("count_after_load", cnt0, 32'd9);
    to_cycle_start();

    // 5: $zero destination: suppressed on dut0, not on dut1; still counted
    send(2'b10, 32'h0, 32'h55, 5'd0, 32'h55, 1'b0, 1'b1);
    wait_drain();
    chk("count_after_zero", cnt0, 32'd10);
    to_cycle_start();

    // 4-bit counter wrap on dut1: 10 + 5 = 15, then one more -> 0
    for (int i = 0; i < 5; i++) begin
      send(2'b10, 32'h0, 32'd100 + i, 5'd3, 32'd100 + i, 1'b1, 1'b1);
    end
    wait_drain();
    chk("count4_at_15", {28'b0, cnt1}, 32'd15);
    to_cycle_start();
    send(2'b10, 32'h0, 32'h77, 5'd3, 32'h77, 1'b1, 1'b1);
    wait_drain();
    chk("count4_wrap",  {28'b0, cnt1}, 32'd0);
    chk("count32_at_16", cnt0,         32'd16);
    to_cycle_start();

    // 6: flush with main and skid full
    out_ready = 1'b0;
    send(2'b10, 32'h0, 32'hF1, 5'd9, 32'hF1, 1'b1, 1'b1);
    send(2'b10, 32'h0, 32'hF2, 5'd9, 32'hF2, 1'b1, 1'b1);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; alu = 32'hF3;
    to_cycle_start();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_outvalid", {31'b0, ov0},       32'd0);
    chk("flush_inready",  {31'b0, in_ready0}, 32'd1);
    chk("flush_count",    cnt0,               32'd16);
    chk("flush_count4",   {28'b0, cnt1},      32'd0);
    // entry accepted during a flush cycle is dropped
    flush = 1'b1; in_valid = 1'b1; alu = 32'hF4;
    to_cycle_start();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_accept", {31'b0, ov0}, 32'd0);
    @(negedge clk);
    chk("flush_drop_stays", {31'b0, ov0}, 32'd0);
    to_cycle_start();
    send(2'b11, 32'h1234, 32'h0, 5'd4, 32'h1234, 1'b1, 1'b1);
    wait_drain();
    chk("count_after_flush", cnt0, 32'd17);
    to_cycle_start();

    // Reset mid-operation, asserted between clock edges
    out_ready = 1'b0;
    send(2'b10, 32'h0, 32'h91, 5'd8, 32'h91, 1'b1, 1'b1);
    send(2'b10, 32'h0, 32'h92, 5'd8, 32'h92, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_outvalid", {31'b0, ov0},       32'd0);
    chk("midrst_inready",  {31'b0, in_ready0}, 32'd1);
    chk("midrst_count",    cnt0,               32'd0);
    chk("midrst_wdata",    wd0,                32'd0);
    chk("midrst_regwrite", {31'b0, rw0},       32'd0);
    #3 rst_n = 1'b1;
    to_cycle_start();
    chk("postrst_outvalid", {31'b0, ov0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1);
  end

endmodule
